s_divider: RTL and testbench

- Iterative radix-2 restoring integer divider for the execute stage. It is the division counterpart of the multiply path.
- Computes quotient and remainder for signed and unsigned operands, one quotient bit per cycle.
- Uses the same in_valid / out_valid / out_ready handshake style as the execute arithmetic units.
- Used for DIV/DIVU/REM/REMU; the consumer selects quotient or remainder.

---
 rtl/s_divider.sv | 137 +++++++++++++
 tb/tb_s_divider.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_divider.sv
// Radix-2 restoring divider: signed/unsigned quotient and remainder,
// one bit per cycle, valid/ready handshake. Optional DIVIDER_FLUSH_EN.
// Ports: clk, rst, [flush], in_valid/in_ready, is_signed, a, b,
//        out_quotient, out_remainder, out_valid/out_ready.
module s_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef DIVIDER_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q;
  logic             negq_q, negr_q;
  logic [WIDTH-1:0] qres_q, rres_q;

  logic             flush_w;
  logic             accept;
  logic             last;
  logic             b_zero, ovf, special;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   rem_sh, diff;

`ifdef DIVIDER_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign accept = in_valid && in_ready && !flush_w;
  assign last   = (cnt_q == CW'(WIDTH-1));

  assign b_zero  = (b == '0);
  assign ovf     = is_signed && (a == {1'b1, {(WIDTH-1){1'b0}}})
                   && (b == '1);
  assign special = b_zero || ovf;

  // |-2^(W-1)| wraps to itself, which is correct read as unsigned
  assign a_abs = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs = (is_signed && b[WIDTH-1]) ? -b : b;

  // Shift in next dividend bit; a borrow in diff means "restore"
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, div_q};
    rem_d  = rem_sh[WIDTH-1:0];
    quo_d  = {quo_q[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_d = diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_w) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept) state_d = special ? DONE : CALC;
        CALC: if (last) state_d = FIX;
        FIX:  state_d = DONE;
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      qres_q <= '0;
      rres_q <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= a_abs;
      div_q  <= b_abs;
      negq_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      negr_q <= is_signed && a[WIDTH-1];
      if (b_zero) begin
        qres_q <= '1;
        rres_q <= a;
      end else if (ovf) begin
        qres_q <= a;
        rres_q <= '0;
      end
    end else if (!flush_w && state_q == CALC) begin
      cnt_q <= cnt_q + 1'b1;
      rem_q <= rem_d;
      quo_q <= quo_d;
    end else if (!flush_w && state_q == FIX) begin
      qres_q <= negq_q ? -quo_q : quo_q;
      rres_q <= negr_q ? -rem_q : rem_q;
    end
  end

  assign out_quotient  = qres_q;
  assign out_remainder = rres_q;

endmodule

// File: tb/tb_s_divider.sv
// Directed bench for s_divider (WIDTH=32).
// Each scenario task checks its own results inline.
module tb_s_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         is_signed = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;
  logic         out_valid;
  logic         out_ready = 1'b0;
`ifdef DIVIDER_FLUSH_EN
  logic         flush = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  s_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
`ifdef DIVIDER_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .is_signed(is_signed),
    .a(a),
    .b(b),
    .out_quotient(out_quotient),
    .out_remainder(out_remainder),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operation and let the next edge accept it
  task automatic start(input logic sg,
                       input logic [W-1:0] x,
                       input logic [W-1:0] y);
    int n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    is_signed = sg;
    a = x;
    b = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 32'hDEADBEEF;
    b = 32'h3;
    is_signed = ~sg;
  endtask

  // Edges after the accept edge until out_valid; 999 on timeout
  task automatic wait_valid(output int cyc, output logic rdy_seen);
    cyc = 0;
    rdy_seen = 1'b0;
    while (!out_valid && cyc < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      step();
      cyc++;
    end
    if (!out_valid) cyc = 999;
  endtask

  task automatic take();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: rdy=%b vld=%b need 0 0",
               in_ready, out_valid);
    end
    total++;
    if (out_quotient !== '0 || out_remainder !== '0) begin
      bad++;
      $display("FAIL reset_out: q=%h r=%h need 0 0",
               out_quotient, out_remainder);
    end
    step();
    step();
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_rel: rdy=%b need 1", in_ready);
    end
  endtask

  task automatic test_unsigned();
    int c;
    logic rs;
    start(1'b0, 32'd100, 32'd7);
    wait_valid(c, rs);
    total++;
    if (c !== W + 1) begin
      bad++;
      $display("FAIL u_lat: got %0d need %0d", c, W + 1);
    end
    total++;
    if (rs !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL u_busy: in_ready seen high during op");
    end
    total++;
    if (out_quotient !== 32'd14 || out_remainder !== 32'd2) begin
      bad++;
      $display("FAIL u_100_7: q=%h r=%h need e 2",
               out_quotient, out_remainder);
    end
    take();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL u_hs: vld=%b rdy=%b need 0 1",
               out_valid, in_ready);
    end
    start(1'b0, 32'h80000000, 32'hFFFFFFFF);
    wait_valid(c, rs);
    total++;
    if (out_quotient !== 32'h0 || out_remainder !== 32'h80000000) begin
      bad++;
      $display("FAIL u_big: q=%h r=%h need 0 80000000",
               out_quotient, out_remainder);
    end
    take();
  endtask

  task automatic test_signed();
    int c;
    logic rs;
    start(1'b1, 32'hFFFFFFF9, 32'h2);
    wait_valid(c, rs);
    total++;
    if (out_quotient !== 32'hFFFFFFFD || out_remainder !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL s_m7_2: q=%h r=%h need fffffffd ffffffff",
               out_quotient, out_remainder);
    end
    take();
    start(1'b1, 32'd7, 32'hFFFFFFFE);
    wait_valid(c, rs);
    total++;
    if (c !== W + 1) begin
      bad++;
      $display("FAIL s_lat: got %0d need %0d", c, W + 1);
    end
    total++;
    if (out_quotient !== 32'hFFFFFFFD || out_remainder !== 32'h1) begin
      bad++;
      $display("FAIL s_7_m2: q=%h r=%h need fffffffd 1",
               out_quotient, out_remainder);
    end
    take();
    start(1'b1, 32'h80000000, 32'h1);
    wait_valid(c, rs);
    total++;
    if (out_quotient !== 32'h80000000 || out_remainder !== 32'h0) begin
      bad++;
      $display("FAIL s_min_1: q=%h r=%h need 80000000 0",
               out_quotient, out_remainder);
    end
    take();
    start(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9);
    wait_valid(c, rs);
    total++;
    if (out_quotient !== 32'd14 || out_remainder !== 32'hFFFFFFFE) begin
      bad++;
      $display("FAIL s_m100_m7: q=%h r=%h need e fffffffe",
               out_quotient, out_remainder);
    end
    take();
  endtask

  task automatic test_special();
    int c;
    logic rs;
    for (int m = 0; m < 2; m++) begin
      start(m[0], 32'd5, 32'd0);
      wait_valid(c, rs);
      total++;
      if (c !== 0) begin
        bad++;
        $display("FAIL dz_lat%0d: got %0d need 0", m, c);
      end
      total++;
      if (out_quotient !== 32'hFFFFFFFF || out_remainder !== 32'd5) begin
        bad++;
        $display("FAIL dz%0d: q=%h r=%h need ffffffff 5",
                 m, out_quotient, out_remainder);
      end
      take();
    end
    start(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_valid(c, rs);
    total++;
    if (c !== 0) begin
      bad++;
      $display("FAIL ovf_lat: got %0d need 0", c);
    end
    total++;
    if (out_quotient !== 32'h80000000 || out_remainder !== 32'h0) begin
      bad++;
      $display("FAIL ovf: q=%h r=%h need 80000000 0",
               out_quotient, out_remainder);
    end
    take();
  endtask

  task automatic test_back_to_back();
    int c;
    logic rs;
    logic stable;
    start(1'b0, 32'd50, 32'd7);
    wait_valid(c, rs);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_quotient !== 32'd7 || out_remainder !== 32'd1)
        stable = 1'b0;
      step();
    end
    total++;
    if (stable !== 1'b1) begin
      bad++;
      $display("FAIL bp_hold: q=%h r=%h vld=%b need 7 1 1",
               out_quotient, out_remainder, out_valid);
    end
    take();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_rel: rdy=%b vld=%b need 1 0",
               in_ready, out_valid);
    end
    start(1'b0, 32'hFFFFFFFF, 32'h10);
    wait_valid(c, rs);
    total++;
    if (out_quotient !== 32'h0FFFFFFF || out_remainder !== 32'hF) begin
      bad++;
      $display("FAIL b2b: q=%h r=%h need 0fffffff f",
               out_quotient, out_remainder);
    end
    take();
  endtask

  task automatic test_async_reset();
    logic seen;
    start(1'b0, 32'd1000, 32'd3);
    for (int i = 0; i < 5; i++) step();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ar_hs: vld=%b rdy=%b need 0 0",
               out_valid, in_ready);
    end
    total++;
    if (out_quotient !== '0 || out_remainder !== '0) begin
      bad++;
      $display("FAIL ar_out: q=%h r=%h need 0 0",
               out_quotient, out_remainder);
    end
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ar_rel: rdy=%b need 1", in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL ar_stale: out_valid=%b need 0", seen);
    end
  endtask

`ifdef DIVIDER_FLUSH_EN
  task automatic test_flush();
    int c;
    logic rs;
    logic seen;
    start(1'b0, 32'd9, 32'd3);
    wait_valid(c, rs);
    take();
    start(1'b0, 32'd100, 32'd9);
    for (int i = 0; i < 3; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL fl_calc: rdy=%b vld=%b need 1 0",
               in_ready, out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    total++;
    if (seen !== 1'b0 || out_quotient !== 32'd3) begin
      bad++;
      $display("FAIL fl_quiet: vld_seen=%b q=%h need 0 3",
               seen, out_quotient);
    end
    start(1'b0, 32'd20, 32'd6);
    wait_valid(c, rs);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL fl_done: vld=%b rdy=%b need 0 1",
               out_valid, in_ready);
    end
    total++;
    if (out_quotient !== 32'd3 || out_remainder !== 32'd2) begin
      bad++;
      $display("FAIL fl_keep: q=%h r=%h need 3 2",
               out_quotient, out_remainder);
    end
    is_signed = 1'b0;
    a = 32'd5;
    b = 32'd0;
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL fl_idle: vld=%b rdy=%b need 0 1",
               out_valid, in_ready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_back_to_back();
    test_async_reset();
`ifdef DIVIDER_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
